int_wire_seq: RTL

//  Sequencer that owns the three inputs of an int_wire instance and steps them through the

---
 rtl/int_wire_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/int_wire_seq.sv
// int_wire_seq
//   Drives the three inputs of an int_wire block through the fixed ramp
//   {in3,in2,in1} = 000, 001, 011, 111. Each step is held for DWELL cycles.
//   On the last cycle of each step, the block captures int_wire's {out2,out1}
//   into result[2k+1:2k], where k is the step number.
//
// Parameters
//   DWELL  cycles each step is held (0 and 1 both mean one cycle)
//   CW     dwell counter width; DWELL must be < 2**CW
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   level request for a pass, sampled in IDLE
//   busy    high while the ramp is running
//   done    one-cycle pulse when a pass completes
//   step    current ramp step 0..3
//   in1-3   drives to int_wire
//   out1-2  returns from int_wire
//   result  packed {out2,out1} captures, one pair per step
//
// Build option
//   INT_WIRE_SEQ_LOOP_EN  when defined, a start held high in DONE restarts the
//                         ramp immediately, so passes run back-to-back.
module int_wire_seq #(
  parameter int DWELL = 20,
  parameter int CW    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [1:0] step,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       out1,
  input  logic       out2,
  output logic [7:0] result
);

  // Terminal count of the dwell counter; DWELL of 0 or 1 collapses to a single cycle.
  localparam logic [CW-1:0] LAST = (DWELL <= 1) ? '0 : CW'(DWELL - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    step_nxt;
  logic [7:0]    result_nxt;
  logic          busy_nxt, done_nxt;
  logic          in1_nxt, in2_nxt, in3_nxt;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    step_nxt   = step;
    result_nxt = result;
    busy_nxt   = busy;
    done_nxt   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_RUN;
          cnt_nxt    = '0;
          step_nxt   = 2'd0;
          result_nxt = 8'h00;
          busy_nxt   = 1'b1;
        end
      end

      S_RUN: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == LAST) begin
          // The int_wire outputs seen here come from this step's drives.
          result_nxt[{step, 1'b0} +: 2] = {out2, out1};
          cnt_nxt = '0;
          if (step != 2'd3) begin
            step_nxt = step + 2'd1;
          end else begin
            state_nxt = S_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
`ifdef INT_WIRE_SEQ_LOOP_EN
        if (start) begin
          state_nxt  = S_RUN;
          cnt_nxt    = '0;
          step_nxt   = 2'd0;
          result_nxt = 8'h00;
          busy_nxt   = 1'b1;
        end
`endif
      end

      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase

    // The drives follow the state and step being entered, so they change on the same edge.
    in1_nxt = (state_nxt == S_DONE) || ((state_nxt == S_RUN) && (step_nxt >= 2'd1));
    in2_nxt = (state_nxt == S_DONE) || ((state_nxt == S_RUN) && (step_nxt >= 2'd2));
    in3_nxt = (state_nxt == S_DONE) || ((state_nxt == S_RUN) && (step_nxt == 2'd3));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      step   <= 2'd0;
      result <= 8'h00;
      busy   <= 1'b0;
      done   <= 1'b0;
      in1    <= 1'b0;
      in2    <= 1'b0;
      in3    <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      step   <= step_nxt;
      result <= result_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      in1    <= in1_nxt;
      in2    <= in2_nxt;
      in3    <= in3_nxt;
    end
  end

endmodule
